// File: rtl/seq_add_ctrl.sv
// seq_add_ctrl: multi-cycle adder that reuses one SLICE-bit adder slice
// across WIDTH/SLICE cycles, carrying between slices through a register.
// Optional macro SEQ_ADD_SUB_EN adds a 'sub' input selecting a - b.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | one slice added per cycle, LSB slice first
// DONE  | result presented (out_valid=1), held until out_ready
module seq_add_ctrl #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   slice_res;
    logic [WIDTH-1:0] b_cap;
    logic             carry_cap;

    // Operand capture: subtraction is a + ~b + 1 through the same slice.
    always_comb begin
        b_cap     = b;
        carry_cap = cin;
`ifdef SEQ_ADD_SUB_EN
        if (sub) begin
            b_cap     = ~b;
            carry_cap = 1'b1;
        end
`endif
    end

    // The shared adder slice, fed by the slice selected by idx_q.
    always_comb begin
        a_sl      = a_q[int'(idx_q)*SLICE +: SLICE];
        b_sl      = b_q[int'(idx_q)*SLICE +: SLICE];
        slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_cap;
                    carry_d = carry_cap;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*SLICE +: SLICE] = slice_res[SLICE-1:0];
                carry_d = slice_res[SLICE];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = slice_res[SLICE];
                    // carry into the MSB is recovered from the MSB sum bit
                    ovf_d   = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_res[SLICE-1]
                              ^ slice_res[SLICE];
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Scoreboard bench for seq_add_ctrl (WIDTH=64, SLICE=8).
// Build with SEQ_ADD_SUB_EN defined to also exercise subtraction.
module tb_seq_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;
    exp_t q[$];

    seq_add_ctrl #(.WIDTH(64), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on handshake.
    initial begin : monitor
        logic ov_prev;
        exp_t e;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: out_valid with no pending op, sum %h", sum);
                    end else begin
                        chk("latency", 64'(cyc - q[0].acc), 64'd8);
                    end
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk("cout", 64'(cout), 64'(e.c));
                    chk("ovf", 64'(ovf), 64'(e.o));
                end
                ov_prev = out_valid;
            end
        end
    end

    task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                         input logic sb, input logic [63:0] es, input logic ec,
                         input logic eo, input bit push);
        int w;
        @(negedge clk);
        a = av;
        b = bv;
        cin = ci;
`ifdef SEQ_ADD_SUB_EN
        sub = sb;
`endif
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) q.push_back('{es, ec, eo, cyc});
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_in_run", 64'(busy), 64'd1);
        chk("in_ready_in_run", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            #3;
            w++;
        end while (!(in_ready && q.size() == 0) && w < 60);
        if (!(in_ready && q.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: in_ready %b pending %0d required 1 and 0",
                     in_ready, q.size());
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;

        out_ready = 1'b1;
        issue(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1);
        wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1);
        wait_idle();
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);
        wait_idle();
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
              64'h0, 1'b1, 1'b1, 1);
        wait_idle();
        issue(64'hFF, 64'h1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0, 1);
        wait_idle();
        issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
        wait_idle();
        issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
              64'h0, 1'b1, 1'b0, 1);
        wait_idle();

        // Backpressure: result must hold and new operands must be refused.
        out_ready = 1'b0;
        issue(64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0, 1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a = 64'd100;
            b = 64'd200;
            cin = 1'b0;
            in_valid = 1'b1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum_hold", sum, 64'd30);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_sum_kept", sum, 64'd30);
        issue(64'd100, 64'd200, 1'b0, 1'b0, 64'd300, 1'b0, 1'b0, 1);
        wait_idle();

        // Asynchronous reset in the middle of RUN discards the operation.
        issue(64'd3, 64'd4, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sum", sum, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1);
        wait_idle();

`ifdef SEQ_ADD_SUB_EN
        issue(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1);
        wait_idle();
        issue(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1);
        wait_idle();
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1);
        wait_idle();
        issue(64'd7, 64'd5, 1'b1, 1'b0, 64'd13, 1'b0, 1'b0, 1);
        wait_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
